sig_delay_ctrl: RTL and testbench

- Sequences runtime delay changes for the sample delay line and generates a trusted-output qualifier for its data.
- Accepts delay requests from the control/register side through a valid/ready handshake, clamps them to the legal range, and commits them to the line only on a sample boundary.
- Masks delay-line output until the line holds enough history for the active delay, and for the read-pipeline drain after every change.
- Sits between the control register bank and the delay line; its `line_delay` output drives the line's delay input, and `data_valid` is shared with the line.

---
 rtl/sig_delay_if.sv | 24 ++
 rtl/sig_delay_ctrl.sv | 110 +++++++++++
 tb/tb_sig_delay_ctrl.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/sig_delay_if.sv
// Control/data bundle between the register bank, the delay controller and the delay line.
// The controller is the slave: it receives requests and sample strobes, returns status.
interface sig_delay_if #(
   parameter int DELAY_BITS = 15
);
   logic [DELAY_BITS-1:0] cfg_delay;
   logic                  cfg_valid;
   logic                  cfg_ready;
   logic                  cfg_err;
   logic                  data_valid;
   logic [DELAY_BITS-1:0] line_delay;
   logic                  out_valid;
   logic                  out_mute;

   modport master (
      output cfg_delay, cfg_valid, data_valid,
      input  cfg_ready, cfg_err, line_delay, out_valid, out_mute
   );

   modport slave (
      input  cfg_delay, cfg_valid, data_valid,
      output cfg_ready, cfg_err, line_delay, out_valid, out_mute
   );
endinterface

// File: rtl/sig_delay_ctrl.sv
// Sequences delay changes onto the sample delay line at sample boundaries and
// qualifies line output until history and read pipeline hold data for the active delay.
module sig_delay_ctrl #(
   parameter int DELAY_BITS = 15,
   parameter int PIPE_LAT   = 2,
   parameter int MIN_DELAY  = 2,
   parameter int MAX_DELAY  = 32760,
   parameter int DEF_DELAY  = 100
) (
   input  logic       clk,
   input  logic       rst_n,
   sig_delay_if.slave bus
);
   localparam int HB = DELAY_BITS + 1;
   localparam int SW = (PIPE_LAT < 1) ? 1 : $clog2(PIPE_LAT + 1);

   typedef enum logic [1:0] {RUN, APPLY, SETTLE} state_t;

   state_t                state_reg, state_next;
   logic [DELAY_BITS-1:0] line_delay_reg, line_delay_next;
   logic [DELAY_BITS-1:0] pending_reg, pending_next;
   logic [SW-1:0]         settle_cnt_reg, settle_cnt_next;
   logic [HB-1:0]         hist_cnt_reg;
   logic                  err_reg, err_next;
   logic [DELAY_BITS-1:0] clamped;
   logic                  out_of_range;
   logic                  accept;
   logic                  ready;
   logic                  mute;
   logic [HB-1:0]         hist_need;
   logic                  hist_ok;

   always_comb begin
      clamped      = bus.cfg_delay;
      out_of_range = 1'b0;
      if (bus.cfg_delay < DELAY_BITS'(MIN_DELAY)) begin
         clamped      = DELAY_BITS'(MIN_DELAY);
         out_of_range = 1'b1;
      end else if (bus.cfg_delay > DELAY_BITS'(MAX_DELAY)) begin
         clamped      = DELAY_BITS'(MAX_DELAY);
         out_of_range = 1'b1;
      end
   end

   assign ready  = (state_reg != APPLY);
   assign accept = bus.cfg_valid & ready;

   // One extra bit keeps line_delay + PIPE_LAT from wrapping.
   assign hist_need = {1'b0, line_delay_reg} + HB'(PIPE_LAT);
   assign hist_ok   = (hist_cnt_reg >= hist_need);

   always_comb begin
      state_next      = state_reg;
      line_delay_next = line_delay_reg;
      pending_next    = pending_reg;
      settle_cnt_next = settle_cnt_reg;
      err_next        = 1'b0;
      if (accept) begin
         // An accept during SETTLE aborts the drain; the new value restarts it on commit.
         pending_next = clamped;
         err_next     = out_of_range;
         if (!((state_reg == RUN) && (clamped == line_delay_reg)))
            state_next = APPLY;
      end else begin
         case (state_reg)
            APPLY: begin
               if (bus.data_valid) begin
                  line_delay_next = pending_reg;
                  settle_cnt_next = SW'(PIPE_LAT);
                  state_next      = (PIPE_LAT == 0) ? RUN : SETTLE;
               end
            end
            SETTLE: begin
               if (bus.data_valid) begin
                  settle_cnt_next = settle_cnt_reg - SW'(1);
                  if (settle_cnt_reg == SW'(1))
                     state_next = RUN;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg      <= RUN;
         line_delay_reg <= DELAY_BITS'(DEF_DELAY);
         pending_reg    <= DELAY_BITS'(DEF_DELAY);
         settle_cnt_reg <= '0;
         hist_cnt_reg   <= '0;
         err_reg        <= 1'b0;
      end else begin
         state_reg      <= state_next;
         line_delay_reg <= line_delay_next;
         pending_reg    <= pending_next;
         settle_cnt_reg <= settle_cnt_next;
         err_reg        <= err_next;
         if (bus.data_valid && (hist_cnt_reg != '1))
            hist_cnt_reg <= hist_cnt_reg + HB'(1);
      end
   end

   assign mute           = (state_reg != RUN) | ~hist_ok;
   assign bus.cfg_ready  = ready;
   assign bus.cfg_err    = err_reg;
   assign bus.line_delay = line_delay_reg;
   assign bus.out_mute   = mute;
   assign bus.out_valid  = bus.data_valid & ~mute;
endmodule

// File: tb/tb_sig_delay_ctrl.sv
// Directed bench for sig_delay_ctrl: expected out_valid per strobe is queued at drive
// time and compared when the strobe is observed.
module tb_sig_delay_ctrl;
   logic clk = 1'b0;
   logic rst_n;
   int   tests = 0;
   int   fails = 0;
   int   hist_n = 0;
   bit   exp_q[$];

   always #5 clk = ~clk;

   sig_delay_if #(.DELAY_BITS(15)) bif ();

   sig_delay_ctrl #(
      .DELAY_BITS(15),
      .PIPE_LAT  (2),
      .MIN_DELAY (2),
      .MAX_DELAY (32760),
      .DEF_DELAY (100)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bif)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // One sample strobe; called just after a rising edge.
   task automatic strobe(input bit exp);
      bit e;
      exp_q.push_back(exp);
      bif.data_valid = 1'b1;
      @(negedge clk);
      e = exp_q.pop_front();
      chk("out_valid", 32'(bif.out_valid), 32'(e));
      @(posedge clk);
      #1;
      bif.data_valid = 1'b0;
      hist_n++;
   endtask

   task automatic request(input int value, input bit exp_err, input bit exp_ready_after);
      $display("[TB] request %0d at hist %0d", value, hist_n);
      bif.cfg_delay  = 15'(value);
      bif.cfg_valid  = 1'b1;
      bif.data_valid = 1'b0;
      @(negedge clk);
      chk("cfg_ready_before", 32'(bif.cfg_ready), 32'd1);
      @(posedge clk);
      #1;
      bif.cfg_valid = 1'b0;
      @(negedge clk);
      chk("cfg_err_pulse", 32'(bif.cfg_err), 32'(exp_err));
      chk("cfg_ready_after", 32'(bif.cfg_ready), 32'(exp_ready_after));
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("cfg_err_clear", 32'(bif.cfg_err), 32'd0);
      chk("cfg_ready_hold", 32'(bif.cfg_ready), 32'(exp_ready_after));
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n          = 1'b0;
      bif.cfg_delay  = '0;
      bif.cfg_valid  = 1'b0;
      bif.data_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_line_delay", 32'(bif.line_delay), 32'd100);
      chk("rst_out_mute", 32'(bif.out_mute), 32'd1);
      chk("rst_out_valid", 32'(bif.out_valid), 32'd0);
      chk("rst_cfg_err", 32'(bif.cfg_err), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("cfg_ready_after_rst", 32'(bif.cfg_ready), 32'd1);
      @(posedge clk);
      #1;

      // Initial fill: strobes 1..102 muted, 103 onward trusted.
      for (int k = 1; k <= 110; k++) strobe(k >= 103);
      chk("fill_line_delay", 32'(bif.line_delay), 32'd100);

      // Decrease to 50 with sparse strobes: commit strobe plus two drain strobes muted.
      request(50, 1'b0, 1'b0);
      strobe(1'b0); idle(3);
      chk("dec_line_delay", 32'(bif.line_delay), 32'd50);
      strobe(1'b0); idle(3);
      strobe(1'b0); idle(3);
      strobe(1'b1); idle(3);
      strobe(1'b1); idle(3);

      // Clamp high, then clamp low while the first is still settling.
      request(32767, 1'b1, 1'b0);
      strobe(1'b0);
      chk("clamp_hi", 32'(bif.line_delay), 32'd32760);
      strobe(1'b0);
      request(0, 1'b1, 1'b0);
      strobe(1'b0);
      chk("clamp_lo", 32'(bif.line_delay), 32'd2);
      strobe(1'b0);
      strobe(1'b0);
      strobe(1'b1);

      // Back to 100, then an equal request is a no-op.
      request(100, 1'b0, 1'b0);
      strobe(1'b0);
      strobe(1'b0);
      strobe(1'b0);
      for (int k = 0; k < 3; k++) strobe(1'b1);
      request(100, 1'b0, 1'b1);
      chk("noop_out_mute", 32'(bif.out_mute), 32'd0);
      for (int k = 0; k < 3; k++) strobe(1'b1);

      // Increase with short history: muted until 1002 samples written.
      while (hist_n < 500) strobe(1'b1);
      request(1000, 1'b0, 1'b0);
      strobe(1'b0);
      chk("inc_line_delay", 32'(bif.line_delay), 32'd1000);
      while (hist_n < 1010) strobe(hist_n >= 1002);

      // 200 then 300 issued during the 200 settle.
      request(200, 1'b0, 1'b0);
      strobe(1'b0);
      chk("b2b_first", 32'(bif.line_delay), 32'd200);
      strobe(1'b0);
      request(300, 1'b0, 1'b0);
      chk("b2b_hold", 32'(bif.line_delay), 32'd200);
      strobe(1'b0);
      chk("b2b_second", 32'(bif.line_delay), 32'd300);
      strobe(1'b0);
      strobe(1'b0);
      strobe(1'b1);
      strobe(1'b1);

      // Reset in the middle of SETTLE.
      request(50, 1'b0, 1'b0);
      strobe(1'b0);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n  = 1'b1;
      hist_n = 0;
      chk("mid_rst_line_delay", 32'(bif.line_delay), 32'd100);
      chk("mid_rst_out_mute", 32'(bif.out_mute), 32'd1);
      chk("mid_rst_cfg_ready", 32'(bif.cfg_ready), 32'd1);
      for (int k = 1; k <= 105; k++) strobe(k >= 103);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
